// File: rtl/dm_byte_ram.sv
// Single-port 32-bit data memory: byte/half/word stores, extended loads, registered read, hardware clear.
// Optional misalignment trapping is enabled by defining DM_ALIGN_CHK_EN.
module dm_byte_ram #(
    parameter int unsigned AW           = 10,
    parameter bit          CLR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sext,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        rvalid,
    output logic        busy,
    output logic        exc
);
    localparam int unsigned DEPTH = 2 ** AW;

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   cnt_q;
    logic [31:0]     mem [DEPTH];

    logic [AW-1:0]   widx;
    logic [1:0]      lane;
    logic            suppress;
    logic            accept;
    logic [3:0]      be;
    logic [31:0]     wdat;
    logic [31:0]     word;
    logic [31:0]     shifted;
    logic [31:0]     load_ext;
    logic            unused_hi;

    assign widx      = addr[AW+1:2];
    assign unused_hi = ^addr[31:AW+2];
    assign busy      = (state_q == CLEAR);
    assign accept    = req && (state_q == IDLE) && !suppress;

`ifdef DM_ALIGN_CHK_EN
    logic misaligned;
    logic exc_q;

    always_comb begin
        misaligned = ((size == 2'b01) && addr[0]) || (size[1] && (addr[1:0] != 2'b00));
        lane       = addr[1:0];
        suppress   = misaligned;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) exc_q <= 1'b0;
        else     exc_q <= req && (state_q == IDLE) && misaligned;
    end

    assign exc = exc_q;
`else
    // Misaligned low address bits are dropped so the access lands on its natural boundary.
    always_comb begin
        suppress = 1'b0;
        case (size)
            2'b00:   lane = addr[1:0];
            2'b01:   lane = {addr[1], 1'b0};
            default: lane = 2'b00;
        endcase
    end

    assign exc = 1'b0;
`endif

    always_comb begin
        case (size)
            2'b00: begin
                be   = 4'b0001 << lane;
                wdat = {4{wd[7:0]}};
            end
            2'b01: begin
                be   = 4'b0011 << {lane[1], 1'b0};
                wdat = {2{wd[15:0]}};
            end
            default: begin
                be   = 4'b1111;
                wdat = wd;
            end
        endcase
    end

    always_comb begin
        word    = mem[widx];
        shifted = word >> {lane, 3'b000};
        case (size)
            2'b00:   load_ext = {{24{sext & shifted[7]}}, shifted[7:0]};
            2'b01:   load_ext = {{16{sext & shifted[15]}}, shifted[15:0]};
            default: load_ext = word;
        endcase
    end

    always_comb begin
        state_d = state_q;
        if ((state_q == CLEAR) && (&cnt_q))
            state_d = IDLE;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= CLR_ON_RESET ? CLEAR : IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == CLEAR)
                cnt_q <= cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            rd     <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= accept && !we;
            if (accept && !we)
                rd <= load_ext;
        end
    end

    // No reset on the array itself; zeroing is done one word per cycle while busy.
    always_ff @(posedge clk) begin
        if (state_q == CLEAR) begin
            mem[cnt_q] <= '0;
        end else if (accept && we) begin
            for (int unsigned i = 0; i < 4; i++)
                if (be[i])
                    mem[widx][8*i +: 8] <= wdat[8*i +: 8];
        end
    end

endmodule

// File: tb/tb_dm_byte_ram.sv
// Randomised self-checking bench for dm_byte_ram (AW=4) against a byte-array reference model.
module tb_dm_byte_ram;
    localparam int unsigned AW    = 4;
    localparam int unsigned NBYTE = 4 * (2 ** AW);
`ifdef DM_ALIGN_CHK_EN
    localparam bit ALN = 1'b1;
`else
    localparam bit ALN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        clr, req, we, sext;
    logic [1:0]  size;
    logic [31:0] addr, wd, rd;
    logic        rvalid, busy, exc;

    int          checks   = 0;
    int          failures = 0;
    logic [7:0]  mb [NBYTE];
    logic [31:0] last_rd;

    dm_byte_ram #(.AW(AW), .CLR_ON_RESET(1'b1)) dut (
        .clk(clk), .clr(clr), .req(req), .we(we), .size(size), .sext(sext),
        .addr(addr), .wd(wd), .rd(rd), .rvalid(rvalid), .busy(busy), .exc(exc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int unsigned nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic int unsigned base_of(input logic [31:0] a, input logic [1:0] sz);
        int unsigned a6 = a % NBYTE;
        return a6 - (a6 % nbytes(sz));
    endfunction

    task automatic model_zero();
        for (int i = 0; i < NBYTE; i++) mb[i] = 8'h00;
        last_rd = '0;
    endtask

    task automatic model_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
        int unsigned b = base_of(a, sz);
        for (int unsigned i = 0; i < nbytes(sz); i++) mb[b + i] = d[8*i +: 8];
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz, input logic sx);
        int unsigned b = base_of(a, sz);
        int unsigned n = nbytes(sz);
        logic [31:0] v = '0;
        for (int unsigned i = 0; i < n; i++) v = v | (32'(mb[b + i]) << (8 * i));
        if (n < 4 && sx && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    task automatic access(input logic w, input logic [1:0] sz, input logic sx,
                          input logic [31:0] a, input logic [31:0] d);
        logic mis, ok;
        mis = ((sz == 2'd1) && a[0]) || ((sz >= 2'd2) && (a[1:0] != 2'd0));
        ok  = !(ALN && mis);
        req = 1'b1; we = w; size = sz; sext = sx; addr = a; wd = d;
        step();
        req = 1'b0;
        if (ok && w)  model_store(a, sz, d);
        if (ok && !w) last_rd = model_load(a, sz, sx);
        chk("rvalid", 32'(rvalid), 32'(ok && !w));
        chk("rd", rd, last_rd);
        chk("exc", 32'(exc), 32'(ALN && mis));
    endtask

    task automatic clear_pulse();
        clr = 1'b1;
        step();
        step();
        clr = 1'b0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 100) begin
            n++;
            step();
        end
    endtask

    initial begin
        int n;
        clr = 1'b0; req = 1'b0; we = 1'b0; size = 2'd0; sext = 1'b0; addr = '0; wd = '0;
        #2 clr = 1'b1;
        #1;
        chk("reset_rd", rd, 32'h0);
        chk("reset_rvalid", 32'(rvalid), 32'h0);
        chk("reset_exc", 32'(exc), 32'h0);
        chk("reset_busy", 32'(busy), 32'h1);
        step();
        clr = 1'b0;
        count_busy(n);
        chk("clear_cycles", n, 32'd16);
        model_zero();
        for (int i = 0; i < 16; i++) access(1'b0, 2'd2, 1'b0, 32'(i * 4), '0);

        access(1'b1, 2'd2, 1'b0, 32'h8, 32'h1122_3344);
        access(1'b1, 2'd0, 1'b0, 32'hA, 32'h0000_00AA);
        access(1'b0, 2'd2, 1'b0, 32'h8, '0);
        chk("byte_merge", rd, 32'h11AA_3344);

        access(1'b1, 2'd2, 1'b0, 32'h0, 32'h8000_FF7F);
        access(1'b0, 2'd0, 1'b1, 32'h0, '0); chk("lb0", rd, 32'h0000_007F);
        access(1'b0, 2'd0, 1'b1, 32'h1, '0); chk("lb1", rd, 32'hFFFF_FFFF);
        access(1'b0, 2'd0, 1'b0, 32'h1, '0); chk("lbu1", rd, 32'h0000_00FF);
        access(1'b0, 2'd1, 1'b1, 32'h2, '0); chk("lh2", rd, 32'hFFFF_8000);
        access(1'b0, 2'd1, 1'b0, 32'h2, '0); chk("lhu2", rd, 32'h0000_8000);

        access(1'b1, 2'd2, 1'b0, 32'h4, 32'hDEAD_BEEF);
        access(1'b0, 2'd2, 1'b0, 32'h4, '0);
        chk("st_then_ld", rd, 32'hDEAD_BEEF);

        access(1'b1, 2'd2, 1'b0, 32'h5, 32'h1234_5678);
        access(1'b0, 2'd2, 1'b0, 32'h4, '0);
        chk("misaligned_word", rd, ALN ? 32'hDEAD_BEEF : 32'h1234_5678);

        // clr reasserted at clear index 7 restarts the full sweep; requests held meanwhile are ignored.
        clear_pulse();
        repeat (7) step();
        chk("midclear_busy", 32'(busy), 32'h1);
        clear_pulse();
        req = 1'b1; we = 1'b1; size = 2'd2; addr = 32'h0; wd = 32'hFFFF_FFFF;
        count_busy(n);
        req = 1'b0;
        chk("restart_cycles", n, 32'd16);
        model_zero();
        access(1'b0, 2'd2, 1'b0, 32'h0, '0);
        access(1'b0, 2'd2, 1'b0, 32'h4, '0);

        access(1'b1, 2'd2, 1'b0, 32'h8, 32'hCAFE_F00D);
        req = 1'b1; we = 1'b0; size = 2'd2; addr = 32'h8;
        step();
        req = 1'b0;
        chk("pend_rvalid", 32'(rvalid), 32'h1);
        clr = 1'b1;
        #1;
        chk("clr_rvalid", 32'(rvalid), 32'h0);
        chk("clr_rd", rd, 32'h0);
        step();
        clr = 1'b0;
        count_busy(n);
        chk("reclear_cycles", n, 32'd16);
        model_zero();

        for (int i = 0; i < 400; i++) begin
            logic        w;
            logic [1:0]  sz;
            logic [31:0] a;
            w  = ($urandom_range(0, 2) == 0);
            sz = 2'($urandom_range(0, 3));
            a  = $urandom();
            access(w, sz, 1'($urandom_range(0, 1)), a, $urandom());
        end
        for (int i = 0; i < 16; i++) access(1'b0, 2'd2, 1'b0, 32'(i * 4), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
